// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared types, field widths and record packing for the event log controller
package log_pkg;

  // Event record field widths
  localparam int TYPE_W = 5;
  localparam int PC_W   = 16;
  localparam int ADDR_W = 16;
  localparam int REC_W  = TYPE_W + PC_W + ADDR_W;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_CAP = 3'd2,
    S_RD_OUT = 3'd3,
    S_CLEAR  = 3'd4
  } log_state_e;

  // Record layout in the log RAM: type in the MSBs, then pc, then address
  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
  } log_rec_t;

  function automatic logic [REC_W-1:0] pack_rec(input logic [TYPE_W-1:0] typ,
                                                input logic [PC_W-1:0]   pc,
                                                input logic [ADDR_W-1:0] addr);
    log_rec_t r;
    r.typ  = typ;
    r.pc   = pc;
    r.addr = addr;
    return r;
  endfunction

endpackage

// File: rtl/log_ctrl.sv
// rtl/log_ctrl.sv - event log controller: capture, drain, clear; optional overwrite-oldest via LOG_WRAP_EN
module log_ctrl
  import log_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  evt_valid,
  input  logic [TYPE_W-1:0]     evt_type,
  input  logic [PC_W-1:0]       evt_pc,
  input  logic [ADDR_W-1:0]     evt_addr,
  input  logic                  drain_req,
  input  logic                  clr_req,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic                  ram_clr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  ovf,
  output logic                  busy
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
  localparam logic [2:0] ST_RD_REQ = 3'(S_RD_REQ);
  localparam logic [2:0] ST_RD_CAP = 3'(S_RD_CAP);
  localparam logic [2:0] ST_RD_OUT = 3'(S_RD_OUT);
  localparam logic [2:0] ST_CLEAR  = 3'(S_CLEAR);

`ifdef LOG_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic in_idle;
  logic in_clear;
  logic in_rd_out;
  logic rd_pop;
  logic wrap_wr;
  logic ovf_set;
  logic drain_go;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_idle   = (state == ST_IDLE);
  assign in_clear  = (state == ST_CLEAR);
  assign in_rd_out = (state == ST_RD_OUT);

  assign full = (count == CNT_W'(DEPTH));

  // Writes only happen from IDLE, so they can never collide with a RAM read.
  // A pending clear swallows the event; when full, only the wrap build writes.
  assign ram_we      = rst_n && in_idle && evt_valid && !clr_req && (!full || WRAP_EN);
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = pack_rec(evt_type, evt_pc, evt_addr);

  // Read address is held across RD_REQ and RD_CAP for a registered-output RAM
  assign ram_re      = (state == ST_RD_REQ) || (state == ST_RD_CAP);
  assign ram_rd_addr = rd_ptr;
  assign ram_clr     = in_clear;

  assign out_valid = in_rd_out;
  assign busy      = !in_idle;

  assign wrap_wr  = ram_we && full;
  assign rd_pop   = in_rd_out && out_ready;
  assign drain_go = in_idle && !clr_req && drain_req && (count != '0);

  // Lost events: anything offered while busy, or while full in IDLE (wrap overwrite also counts)
  assign ovf_set = evt_valid && ((in_idle && !clr_req && full) || !in_idle);

  // Next-state selection; clear wins over drain and event capture
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nx = ST_CLEAR;
        end else if (drain_go) begin
          state_nx = ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_nx = ST_RD_CAP;
      ST_RD_CAP: state_nx = ST_RD_OUT;
      ST_RD_OUT: begin
        if (rd_pop) begin
          state_nx = (count > CNT_W'(1)) ? ST_RD_REQ : ST_IDLE;
        end
      end
      ST_CLEAR: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State, pointers, occupancy, sticky overflow and drain output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (in_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (ram_we) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        // Overwriting the oldest record drops it, so the read pointer follows
        if (wrap_wr || rd_pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (ram_we && !full) begin
          count <= count + 1'b1;
        end else if (rd_pop) begin
          count <= count - 1'b1;
        end
        if (ovf_set) begin
          ovf <= 1'b1;
        end
      end
      if (state == ST_RD_CAP) begin
        out_data <= ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_log_ctrl.sv
// tb/tb_log_ctrl.sv - self-checking bench for log_ctrl (vector table, directed corners, random vs. queue model)
module tb_log_ctrl;
  import log_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 37;
  localparam int DEPTH = 64;
`ifdef LOG_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evt_valid = 1'b0;
  logic [4:0]    evt_type = '0;
  logic [15:0]   evt_pc = '0;
  logic [15:0]   evt_addr = '0;
  logic          drain_req = 1'b0;
  logic          clr_req = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic [AW-1:0] ram_wr_addr;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_we;
  logic          ram_re;
  logic          ram_clr;
  logic [DW-1:0] ram_rd_data = '0;
  logic [AW:0]   count;
  logic          full;
  logic          ovf;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  log_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_type(evt_type),
    .evt_pc(evt_pc), .evt_addr(evt_addr), .drain_req(drain_req), .clr_req(clr_req),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr), .ram_wr_data(ram_wr_data),
    .ram_we(ram_we), .ram_re(ram_re), .ram_clr(ram_clr), .ram_rd_data(ram_rd_data),
    .count(count), .full(full), .ovf(ovf), .busy(busy)
  );

  // Log RAM with one-cycle registered read
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_re) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; evt_valid = 1'b0; drain_req = 1'b0; clr_req = 1'b0; out_ready = 1'b1;
    next_cyc(); next_cyc();
    rst_n = 1'b1;
  endtask

  // Offer one event and expect it written at wa
  task automatic put_evt(input logic [15:0] pc, input logic [AW-1:0] wa);
    evt_valid = 1'b1; evt_type = 5'd3; evt_pc = pc; evt_addr = 16'h0B00;
    @(negedge clk);
    chk("put we", ram_we, 1'b1);
    chk("put addr", ram_wr_addr, wa);
    exp_q.push_back({5'd3, pc, 16'h0B00});
    next_cyc();
    evt_valid = 1'b0;
  endtask

  // Called at a negedge; consumes exp_q from the drain stream
  task automatic finish_drain(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      if (out_valid && out_ready) chk({tag, " rec"}, out_data, exp_q.pop_front());
      next_cyc(); @(negedge clk); guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s timeout: %0d records left, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    chk({tag, " busy end"}, busy, 1'b0);
    chk({tag, " count end"}, count, 0);
    next_cyc();
  endtask

  // Called at a negedge; bounded wait until out_valid is up
  task automatic wait_valid(input string tag);
    int guard = 0;
    while (!out_valid && guard < 6) begin
      next_cyc(); @(negedge clk); guard++;
    end
    chk({tag, " reach out_valid"}, out_valid, 1'b1);
  endtask

  typedef struct {
    logic        ev;
    logic [15:0] pc;
    logic        dr;
    logic        we;
    logic [7:0]  wa;
    logic        re;
    logic        ov;
    logic [36:0] od;
    logic [8:0]  cnt;
    logic        bsy;
  } vec_t;

  function automatic vec_t mk(input logic ev, input logic [15:0] pc, input logic dr,
                              input logic we, input logic [7:0] wa, input logic re,
                              input logic ov, input logic [15:0] opc,
                              input logic [8:0] cnt, input logic bsy);
    vec_t v;
    v.ev = ev; v.pc = pc; v.dr = dr; v.we = we; v.wa = wa; v.re = re;
    v.ov = ov; v.od = {5'd1, opc, 16'h0200}; v.cnt = cnt; v.bsy = bsy;
    return v;
  endfunction

  vec_t tv[14];

  initial begin
    logic [DW-1:0] rec;
    logic          m_act, m_clr, m_ovf, m_idle, exp_we, exp_ov;
    int            m_wait, sz;
    logic [DW-1:0] rq[$];

    tv[0]  = mk(1, 16'hE000, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
    tv[1]  = mk(1, 16'hE002, 0, 1, 1, 0, 0, 16'h0000, 1, 0);
    tv[2]  = mk(1, 16'hE004, 0, 1, 2, 0, 0, 16'h0000, 2, 0);
    tv[3]  = mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 3, 0);
    tv[4]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 3, 1);
    tv[5]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 3, 1);
    tv[6]  = mk(0, 16'h0000, 0, 0, 0, 0, 1, 16'hE000, 3, 1);
    tv[7]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 2, 1);
    tv[8]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 2, 1);
    tv[9]  = mk(0, 16'h0000, 0, 0, 0, 0, 1, 16'hE002, 2, 1);
    tv[10] = mk(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 1);
    tv[11] = mk(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 1);
    tv[12] = mk(0, 16'h0000, 0, 0, 0, 0, 1, 16'hE004, 1, 1);
    tv[13] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst count", count, 0);
    chk("rst busy", busy, 1'b0);
    chk("rst full", full, 1'b0);
    chk("rst ovf", ovf, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 0);
    chk("rst ram_re", ram_re, 1'b0);
    chk("rst ram_clr", ram_clr, 1'b0);
    next_cyc();
    // Drain on an empty log is ignored
    drain_req = 1'b1;
    next_cyc();
    drain_req = 1'b0;
    @(negedge clk);
    chk("empty drain busy", busy, 1'b0);
    next_cyc();

    // Three events then a drain with latency and order checks
    for (int i = 0; i < 14; i++) begin
      evt_valid = tv[i].ev; evt_type = 5'd1; evt_pc = tv[i].pc; evt_addr = 16'h0200;
      drain_req = tv[i].dr; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d we", i), ram_we, tv[i].we);
      if (tv[i].we) begin
        chk($sformatf("vec%0d wa", i), ram_wr_addr, tv[i].wa);
        chk($sformatf("vec%0d wd", i), ram_wr_data, {5'd1, tv[i].pc, 16'h0200});
      end
      chk($sformatf("vec%0d re", i), ram_re, tv[i].re);
      chk($sformatf("vec%0d out_valid", i), out_valid, tv[i].ov);
      if (tv[i].ov) chk($sformatf("vec%0d out_data", i), out_data, tv[i].od);
      chk($sformatf("vec%0d count", i), count, tv[i].cnt);
      chk($sformatf("vec%0d busy", i), busy, tv[i].bsy);
      next_cyc();
    end
    evt_valid = 1'b0; drain_req = 1'b0;

    // Backpressure: output held while events are dropped
    do_reset();
    exp_q.delete();
    put_evt(16'h1111, 0);
    put_evt(16'h2222, 1);
    drain_req = 1'b1; out_ready = 1'b0;
    next_cyc();
    drain_req = 1'b0;
    @(negedge clk);
    wait_valid("stall");
    evt_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall out_valid", out_valid, 1'b1);
      chk("stall out_data", out_data, exp_q[0]);
      chk("stall count", count, 2);
      chk("stall no we", ram_we, 1'b0);
      next_cyc(); evt_pc = 16'($urandom); @(negedge clk);
    end
    evt_valid = 1'b0;
    chk("stall ovf", ovf, 1'b1);
    chk("stall data end", out_data, exp_q[0]);
    out_ready = 1'b1;
    finish_drain("stall");

    // Clear beats drain and event in the same cycle
    put_evt(16'h3333, 2);
    put_evt(16'h4444, 3);
    exp_q.delete();
    clr_req = 1'b1; drain_req = 1'b1; evt_valid = 1'b1; evt_pc = 16'h5555;
    @(negedge clk);
    chk("clr cycle we", ram_we, 1'b0);
    next_cyc();
    clr_req = 1'b0; drain_req = 1'b0; evt_valid = 1'b0;
    @(negedge clk);
    chk("clr pulse", ram_clr, 1'b1);
    chk("clr busy", busy, 1'b1);
    next_cyc();
    @(negedge clk);
    chk("clr pulse end", ram_clr, 1'b0);
    chk("clr count", count, 0);
    chk("clr ovf", ovf, 1'b0);
    chk("clr busy end", busy, 1'b0);
    repeat (3) next_cyc();
    @(negedge clk);
    chk("clr no drain", out_valid, 1'b0);
    chk("clr still idle", busy, 1'b0);
    next_cyc();

    // Reset in the middle of a drain
    put_evt(16'h6666, 0);
    put_evt(16'h7777, 1);
    exp_q.delete();
    drain_req = 1'b1; out_ready = 1'b0;
    next_cyc();
    drain_req = 1'b0;
    @(negedge clk);
    wait_valid("mid rst");
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid rst out_valid", out_valid, 1'b0);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst count", count, 0);
    chk("mid rst out_data", out_data, 0);
    next_cyc();
    out_ready = 1'b1;
    put_evt(16'h8888, 0);
    exp_q.delete();

    // Fill to DEPTH, then one more event
    do_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      evt_valid = 1'b1; evt_type = 5'(i); evt_pc = 16'(i); evt_addr = 16'h0A00;
      @(negedge clk);
      chk($sformatf("fill%0d wa", i), ram_wr_addr, 8'(i));
      exp_q.push_back({5'(i), 16'(i), 16'h0A00});
      next_cyc();
    end
    evt_type = 5'd31; evt_pc = 16'hFFFF;
    @(negedge clk);
    chk("full flag", full, 1'b1);
    chk("full count", count, DEPTH);
    chk("full extra we", ram_we, WRAP);
    chk("full wr addr", ram_wr_addr, 0);
    if (WRAP) begin
      void'(exp_q.pop_front());
      exp_q.push_back({5'd31, 16'hFFFF, 16'h0A00});
    end
    next_cyc();
    evt_valid = 1'b0;
    @(negedge clk);
    chk("full ovf", ovf, 1'b1);
    chk("full count after", count, DEPTH);
    chk("full flag after", full, 1'b1);
    next_cyc();
    drain_req = 1'b1;
    next_cyc();
    drain_req = 1'b0;
    @(negedge clk);
    finish_drain("full");

    // Random traffic against a queue-level model
    do_reset();
    rq.delete();
    m_act = 0; m_clr = 0; m_ovf = 0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      evt_valid = 1'($urandom_range(0, 1));
      evt_type  = 5'($urandom);
      evt_pc    = 16'($urandom);
      evt_addr  = 16'($urandom);
      drain_req = ($urandom_range(0, 19) == 0);
      clr_req   = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rec = {evt_type, evt_pc, evt_addr};
      @(negedge clk);
      m_idle = !m_act && !m_clr;
      exp_we = rst_n && m_idle && evt_valid && !clr_req && (rq.size() < DEPTH || WRAP);
      exp_ov = m_act && (m_wait == 0);
      chk("rnd busy", busy, !m_idle);
      chk("rnd out_valid", out_valid, exp_ov);
      chk("rnd count", count, rq.size());
      chk("rnd full", full, rq.size() == DEPTH);
      chk("rnd ovf", ovf, m_ovf);
      chk("rnd ram_we", ram_we, exp_we);
      chk("rnd ram_clr", ram_clr, m_clr);
      if (exp_we) chk("rnd wr data", ram_wr_data, rec);
      if (exp_ov) chk("rnd out_data", out_data, rq[0]);
      if (!rst_n) begin
        rq.delete(); m_act = 0; m_clr = 0; m_ovf = 0; m_wait = 0;
      end else if (m_clr) begin
        rq.delete(); m_ovf = 0; m_clr = 0;
      end else if (m_idle) begin
        if (clr_req) begin
          m_clr = 1;
        end else begin
          sz = rq.size();
          if (evt_valid) begin
            if (sz < DEPTH) begin
              rq.push_back(rec);
            end else begin
              m_ovf = 1;
              if (WRAP) begin
                void'(rq.pop_front());
                rq.push_back(rec);
              end
            end
          end
          if (drain_req && sz > 0) begin
            m_act = 1; m_wait = 2;
          end
        end
      end else begin
        if (evt_valid) m_ovf = 1;
        if (m_wait > 0) begin
          m_wait--;
        end else if (out_ready) begin
          void'(rq.pop_front());
          if (rq.size() > 0) m_wait = 2;
          else m_act = 0;
        end
      end
      next_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/log_ctrl.md
LOG_CTRL -- requirements
Module: log_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: log RAM address width.
REQ-002 Parameter DATA_WIDTH, default 37: record width, fixed at 37 = 5+16+16.
REQ-003 Parameter DEPTH, default 64: number of usable entries; DEPTH <= 2**ADDR_WIDTH.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 evt_valid  in  1  one event record offered this cycle.
REQ-007 evt_type/evt_pc/evt_addr  in  5/16/16  event fields.
REQ-008 drain_req, clr_req  in  1 each  single-cycle command pulses.
REQ-009 out_valid out 1; out_data out 37; out_ready in 1: drain output, valid/ready handshake.
REQ-010 ram_wr_addr, ram_rd_addr out ADDR_WIDTH; ram_wr_data out 37; ram_we, ram_re, ram_clr out 1; ram_rd_data in 37: log RAM port.
REQ-011 count out ADDR_WIDTH+1; full out 1; ovf out 1 (sticky); busy out 1.

Function
REQ-012 FSM states: IDLE, RD_REQ, RD_CAP, RD_OUT, CLEAR; busy=1 in every state except IDLE.
REQ-013 Record packing: ram_wr_data = {evt_type, evt_pc, evt_addr}, type in the MSBs.
REQ-014 IDLE with evt_valid and not full: ram_we=1 at wr_ptr in the same cycle; wr_ptr+1 modulo DEPTH; count+1.
REQ-015 evt_valid outside IDLE, or when full without LOG_WRAP_EN: event dropped, ovf set next cycle.
REQ-016 ram_we and ram_re are never both 1 in the same cycle.
REQ-017 IDLE with clr_req: go to CLEAR; clr_req has priority over drain_req and evt_valid; the event in that cycle is dropped without setting ovf.
REQ-018 CLEAR lasts 1 cycle: ram_clr=1; wr_ptr, rd_ptr, count and ovf go to 0; return to IDLE.
REQ-019 IDLE with drain_req and count>0: go to RD_REQ. An event accepted in the same cycle is written and included in the drain. drain_req with count==0 is ignored.
REQ-020 RD_REQ: ram_re=1, ram_rd_addr=rd_ptr; go to RD_CAP.
REQ-021 RD_CAP: ram_re held at 1 and ram_rd_addr held; out_data captured from ram_rd_data; go to RD_OUT.
REQ-022 RD_OUT: out_valid=1, out_data stable until out_ready. On out_valid&out_ready: rd_ptr+1 modulo DEPTH; count-1; go to RD_REQ if the new count>0, else IDLE.
REQ-023 Drain latency: first out_valid is 3 cycles after the drain_req cycle.
REQ-024 clr_req outside IDLE is ignored; drain_req outside IDLE is ignored.
REQ-025 full = (count==DEPTH); pointers wrap from DEPTH-1 to 0.
REQ-026 ovf is cleared only by reset or CLEAR.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE; wr_ptr=rd_ptr=count=0; ovf=0; out_valid=0; out_data=0; ram_we=ram_re=ram_clr=0; busy=0; full=0.
REQ-028 Reset mid-drain aborts the drain immediately; the next cycle behaves as after power-up. RAM contents are not cleared by reset.

Configuration
REQ-029 Macro LOG_WRAP_EN, when defined: an event in IDLE while full is written at wr_ptr; wr_ptr and rd_ptr both advance; count stays DEPTH; ovf is set (oldest record lost).
REQ-030 Without LOG_WRAP_EN: events while full are dropped per REQ-015 and the RAM is untouched.

Structure
REQ-031 Shared package log_pkg holds: state enum, field widths (TYPE_W=5, PC_W=16, ADDR_W=16, REC_W=37) and the record pack order.
REQ-032 No sub-module; the FSM, pointers and counter are in one module, and the RAM is instantiated outside.

Verification
REQ-033 Reset, then 3 events (type 1, pc 0xE000/0xE002/0xE004, addr 0x0200) -> count=3; ram_wr_addr 0,1,2; ram_wr_data = {5'd1,16'hE000,16'h0200} first.
REQ-034 drain_req with out_ready=1 -> out_valid first at +3 cycles; records emerge in order 0xE000, 0xE002, 0xE004; then count=0, busy=0.
REQ-035 64 events then 1 more, without LOG_WRAP_EN -> full=1, ovf=1, count=64, no 65th ram_we.
REQ-036 Same with LOG_WRAP_EN -> 65th written at address 0; drain yields 64 records starting with the 2nd event.
REQ-037 Drain with out_ready=0 for 5 cycles, evt_valid asserted meanwhile -> out_data stable, ovf=1, count unchanged.
REQ-038 clr_req together with drain_req and evt_valid in IDLE -> ram_clr pulse for 1 cycle, count=0, ovf=0, no drain; rst_n=0 during RD_OUT -> out_valid=0 next cycle.
